pe_feeder: RTL and testbench

PE_FEEDER -- requirements
Module: pe_feeder

---
 rtl/pe_feeder_pkg.sv | 22 ++
 rtl/pe_feeder.sv | 166 ++++++++++++++++
 tb/tb_pe_feeder.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_feeder_pkg.sv
// pe_feeder_pkg: shared definitions for the PE operand feeder.
//   XLEN          - operand / result width
//   DATA_RANGE    - number of distinct XLEN-bit values
//   DRAIN_TIMEOUT - cycles DRAIN waits for a PE result before giving up
//   state_e       - feeder FSM states
package pe_feeder_pkg;

  localparam int XLEN       = 16;
  localparam int DATA_RANGE = 1 << XLEN;

  localparam logic [3:0] DRAIN_TIMEOUT = 4'd15;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MAC   = 3'd1,
    ST_BIAS  = 3'd2,
    ST_RELU  = 3'd3,
    ST_FLUSH = 3'd4,
    ST_DRAIN = 3'd5
  } state_e;

endpackage

// File: rtl/pe_feeder.sv
// pe_feeder: sequences one MAC job into a processing element.
// A command gives the number of operand pairs (cmd_len) and whether to apply
// ReLU. The feeder streams cmd_len operand pairs plus one bias pair to the PE
// as registered micro-ops, optionally issues a ReLU cycle, flushes the PE and
// waits (bounded) for the PE result, then reports it with a one-cycle pulse.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   cmd_valid/cmd_ready        command handshake (ready only in IDLE)
//   cmd_len, cmd_relu          job length and ReLU enable
//   op_valid/op_ready          operand stream handshake (ready in MAC, BIAS)
//   op_x, op_w                 operand pair (bias pair: x=1, w=bias)
//   pe_in_valid .. pe_flush    registered PE micro-op controls
//   pe_x, pe_weight            registered operands to the PE
//   pe_out_valid, pe_result    PE result return
//   pe_illegal                 PE reports an illegal micro-op
//   res_valid, res_data        job-complete pulse and captured result
//   res_err                    error qualifier for res_valid
//   busy                       high whenever not IDLE
//   state                      current FSM state (debug observation)
//
// Handshakes: a transfer occurs on a rising edge where valid and ready are
// both high; valid never depends on ready, and ready here depends only on the
// FSM state.
module pe_feeder
  import pe_feeder_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [15:0]     cmd_len,
  input  logic            cmd_relu,
  input  logic            op_valid,
  output logic            op_ready,
  input  logic [XLEN-1:0] op_x,
  input  logic [XLEN-1:0] op_w,
  output logic            pe_in_valid,
  output logic            pe_calc_bias,
  output logic            pe_calc_relu,
  output logic            pe_out_en,
  output logic            pe_flush,
  output logic [XLEN-1:0] pe_x,
  output logic [XLEN-1:0] pe_weight,
  input  logic            pe_out_valid,
  input  logic [XLEN-1:0] pe_result,
  input  logic            pe_illegal,
  output logic            res_valid,
  output logic [XLEN-1:0] res_data,
  output logic            res_err,
  output logic            busy,
  output state_e          state
);

  state_e      state_nx;
  logic [15:0] len_q;
  logic [15:0] cnt_q;
  logic        relu_q;
  logic        cap_q;
  logic        err_q;
  logic [3:0]  tmo_q;

  logic        op_hs;
  logic        cmd_hs;
  logic        drain_exit;
  logic        new_capture;

  // cmd_ready is gated by rst_n so it stays low for the whole reset pulse.
  assign cmd_ready   = rst_n && (state == ST_IDLE);
  assign op_ready    = (state == ST_MAC) || (state == ST_BIAS);
  assign busy        = (state != ST_IDLE);
  assign op_hs       = op_valid && op_ready;
  assign cmd_hs      = cmd_valid && cmd_ready;
  assign new_capture = busy && pe_out_valid && !cap_q;

  always_comb begin
    state_nx   = state;
    drain_exit = 1'b0;
    case (state)
      ST_IDLE:  if (cmd_hs) state_nx = (cmd_len != 16'd0) ? ST_MAC : ST_BIAS;
      ST_MAC:   if (op_hs && (cnt_q + 16'd1 == len_q)) state_nx = ST_BIAS;
      ST_BIAS:  if (op_hs) state_nx = relu_q ? ST_RELU : ST_FLUSH;
      ST_RELU:  state_nx = ST_FLUSH;
      ST_FLUSH: state_nx = ST_DRAIN;
      ST_DRAIN: begin
        // A result arriving in this very cycle also ends the wait.
        if (cap_q || pe_out_valid || (tmo_q == DRAIN_TIMEOUT - 4'd1)) begin
          drain_exit = 1'b1;
          state_nx   = ST_IDLE;
        end
      end
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q        <= '0;
      cnt_q        <= '0;
      relu_q       <= 1'b0;
      cap_q        <= 1'b0;
      err_q        <= 1'b0;
      tmo_q        <= '0;
      pe_in_valid  <= 1'b0;
      pe_calc_bias <= 1'b0;
      pe_calc_relu <= 1'b0;
      pe_out_en    <= 1'b0;
      pe_flush     <= 1'b0;
      pe_x         <= '0;
      pe_weight    <= '0;
      res_valid    <= 1'b0;
      res_err      <= 1'b0;
      res_data     <= '0;
    end else begin
      // Micro-ops are one cycle behind the state/handshake that produced
      // them; a cycle without an operand handshake yields an all-zero
      // control bubble while pe_x/pe_weight hold.
      pe_in_valid  <= op_hs;
      pe_calc_bias <= op_hs && (state == ST_BIAS);
      pe_out_en    <= (op_hs && (state == ST_BIAS) && !relu_q) || (state == ST_RELU);
      pe_calc_relu <= (state == ST_RELU);
      pe_flush     <= (state == ST_FLUSH);
      res_valid    <= 1'b0;
      res_err      <= 1'b0;

      if (op_hs) begin
        pe_x      <= op_x;
        pe_weight <= op_w;
      end

      if (cmd_hs) begin
        len_q  <= cmd_len;
        relu_q <= cmd_relu;
        cnt_q  <= '0;
        cap_q  <= 1'b0;
        err_q  <= 1'b0;
      end

      if ((state == ST_MAC) && op_hs) cnt_q <= cnt_q + 16'd1;

      // Only the first result of a job is kept.
      if (new_capture) begin
        res_data <= pe_result;
        cap_q    <= 1'b1;
      end

      if (busy && pe_illegal) err_q <= 1'b1;

      if (state == ST_DRAIN) begin
        tmo_q <= tmo_q + 4'd1;
        if (drain_exit) begin
          tmo_q     <= '0;
          res_valid <= 1'b1;
          // Exiting without any result means the wait timed out.
          res_err   <= err_q || pe_illegal || (!cap_q && !pe_out_valid);
        end
      end
    end
  end

endmodule

// File: tb/tb_pe_feeder.sv
// tb_pe_feeder: directed, table-driven bench for pe_feeder with a behavioural
// PE (accumulator, bias add, ReLU, registered result) and a micro-op monitor.
module tb_pe_feeder;
  import pe_feeder_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic [15:0]     cmd_len = '0;
  logic            cmd_relu = 1'b0;
  logic            op_valid = 1'b0;
  logic            op_ready;
  logic [XLEN-1:0] op_x = '0;
  logic [XLEN-1:0] op_w = '0;
  logic            pe_in_valid, pe_calc_bias, pe_calc_relu, pe_out_en, pe_flush;
  logic [XLEN-1:0] pe_x, pe_weight;
  logic            pe_out_valid;
  logic [XLEN-1:0] pe_result;
  logic            pe_illegal = 1'b0;
  logic            res_valid;
  logic [XLEN-1:0] res_data;
  logic            res_err;
  logic            busy;
  state_e          state;

  pe_feeder dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len), .cmd_relu(cmd_relu),
    .op_valid(op_valid), .op_ready(op_ready), .op_x(op_x), .op_w(op_w),
    .pe_in_valid(pe_in_valid), .pe_calc_bias(pe_calc_bias), .pe_calc_relu(pe_calc_relu),
    .pe_out_en(pe_out_en), .pe_flush(pe_flush), .pe_x(pe_x), .pe_weight(pe_weight),
    .pe_out_valid(pe_out_valid), .pe_result(pe_result), .pe_illegal(pe_illegal),
    .res_valid(res_valid), .res_data(res_data), .res_err(res_err), .busy(busy),
    .state(state)
  );

  // ---------------- behavioural PE ----------------
  logic                   pe_dead = 1'b0;
  logic signed [XLEN-1:0] acc, acc_n, px, pw;
  assign px = pe_x;
  assign pw = pe_weight;

  always_comb begin
    acc_n = acc;
    if (pe_in_valid) acc_n = acc + XLEN'(px * pw);
    if (pe_calc_relu && acc_n < 0) acc_n = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc          <= '0;
      pe_out_valid <= 1'b0;
      pe_result    <= '0;
    end else begin
      acc          <= pe_flush ? '0 : acc_n;
      pe_out_valid <= pe_out_en && !pe_dead;
      pe_result    <= acc_n;
    end
  end

  // ---------------- scoreboard bookkeeping ----------------
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- micro-op monitor ----------------
  logic            mon_en = 1'b0;
  int              cyc = 0;
  int              n_inv, n_bias_oe, n_relu, n_flush, n_odd, n_hold, n_rv, drain_at, lat;
  logic [XLEN-1:0] mon_data, prev_x, prev_w;
  logic            mon_err;
  state_e          prev_state;
  logic [4:0]      ctl;
  assign ctl = {pe_in_valid, pe_calc_bias, pe_calc_relu, pe_out_en, pe_flush};

  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      if (pe_in_valid) n_inv++;
      case (ctl)
        5'b10000, 5'b11000, 5'b00000: ;
        5'b11010: n_bias_oe++;
        5'b00110: n_relu++;
        5'b00001: n_flush++;
        default:  n_odd++;
      endcase
      if (!pe_in_valid && (pe_x !== prev_x || pe_weight !== prev_w)) n_hold++;
      if (state == ST_DRAIN && prev_state != ST_DRAIN) drain_at = cyc;
      if (res_valid) begin
        n_rv++;
        mon_data = res_data;
        mon_err  = res_err;
        lat      = cyc - drain_at;
      end
    end
    prev_x     = pe_x;
    prev_w     = pe_weight;
    prev_state = state;
  end

  // ---------------- vector table ----------------
  typedef struct {
    int              len;
    bit              relu;
    int              x;
    int              w;
    int              bias;
    bit              toggle;
    bit              dead;
    int              ill_at;
    bit              noise;
    logic [XLEN-1:0] exp_data;
    bit              exp_err;
    int              exp_inv;
    int              exp_lat;
  } vec_t;

  vec_t vecs[8];

  // ---------------- driver tasks ----------------
  // Sends operand pairs until n_send handshakes are done; pair total-1 is bias.
  task automatic drive_ops(input int n_send, input int total_pairs, input int x, input int w,
                           input int bias, input bit toggle, input int ill_at);
    int sent = 0;
    int guard = 0;
    bit v = 1'b0;
    while (sent < n_send && guard < 400) begin
      @(negedge clk);
      guard++;
      v = toggle ? ~v : 1'b1;
      op_valid = v;
      if (sent == total_pairs - 1) begin
        op_x = XLEN'(1);
        op_w = bias[XLEN-1:0];
      end else begin
        op_x = x[XLEN-1:0];
        op_w = w[XLEN-1:0];
      end
      pe_illegal = (ill_at >= 0) && (sent == ill_at);
      if (op_valid && op_ready) sent++;
    end
    if (sent < n_send) chk("op_stream_timeout", 32'(sent), 32'(n_send));
  endtask

  task automatic run_vec(input int i);
    vec_t v = vecs[i];
    int guard = 0;
    @(negedge clk);
    chk($sformatf("v%0d_cmd_ready", i), 32'(cmd_ready), 32'd1);
    chk($sformatf("v%0d_idle_busy", i), 32'(busy), 32'd0);
    n_inv = 0; n_bias_oe = 0; n_relu = 0; n_flush = 0; n_odd = 0; n_hold = 0; n_rv = 0;
    drain_at = 0; lat = -1; mon_data = '0; mon_err = 1'b0;
    pe_dead  = v.dead;
    mon_en   = 1'b1;
    cmd_valid = 1'b1;
    cmd_len   = 16'(v.len);
    cmd_relu  = v.relu;
    @(negedge clk);
    // With noise on, a second command is held high throughout the job.
    cmd_valid = v.noise;
    cmd_len   = 16'd7;
    drive_ops(v.len + 1, v.len + 1, v.x, v.w, v.bias, v.toggle, v.ill_at);
    @(negedge clk);
    op_valid = 1'b0; pe_illegal = 1'b0; cmd_valid = 1'b0;
    while (n_rv == 0 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (n_rv == 0) chk($sformatf("v%0d_res_valid_timeout", i), 32'd0, 32'd1);
    repeat (3) @(negedge clk);
    mon_en  = 1'b0;
    pe_dead = 1'b0;
    chk($sformatf("v%0d_res_data", i), 32'(mon_data), 32'(v.exp_data));
    chk($sformatf("v%0d_res_err", i), 32'(mon_err), 32'(v.exp_err));
    chk($sformatf("v%0d_res_pulses", i), 32'(n_rv), 32'd1);
    chk($sformatf("v%0d_in_valid_cycles", i), 32'(n_inv), 32'(v.exp_inv));
    chk($sformatf("v%0d_bias_out_en", i), 32'(n_bias_oe), 32'(v.relu ? 0 : 1));
    chk($sformatf("v%0d_relu_cycles", i), 32'(n_relu), 32'(v.relu ? 1 : 0));
    chk($sformatf("v%0d_flush_cycles", i), 32'(n_flush), 32'd1);
    chk($sformatf("v%0d_bad_ctl_patterns", i), 32'(n_odd), 32'd0);
    chk($sformatf("v%0d_bubble_hold", i), 32'(n_hold), 32'd0);
    chk($sformatf("v%0d_drain_latency", i), 32'(lat), 32'(v.exp_lat));
  endtask

  // ---------------- test ----------------
  initial begin
    //           len relu  x   w bias tog dead ill noise data    err inv lat
    vecs[0] = '{32, 1'b0,  1,  1,  1, 1'b0, 1'b0, -1, 1'b0, 16'd33, 1'b0, 33,  1};
    vecs[1] = '{16, 1'b1, -1,  1,  0, 1'b0, 1'b0, -1, 1'b0, 16'd0,  1'b0, 17,  1};
    vecs[2] = '{ 8, 1'b0,  1,  1,  1, 1'b1, 1'b0, -1, 1'b0, 16'd9,  1'b0,  9,  1};
    vecs[3] = '{ 0, 1'b0,  0,  0,  5, 1'b0, 1'b0, -1, 1'b0, 16'd5,  1'b0,  1,  1};
    vecs[4] = '{ 4, 1'b0,  2,  3,  1, 1'b0, 1'b1, -1, 1'b0, 16'd5,  1'b1,  5, 15};
    vecs[5] = '{ 6, 1'b0,  2,  3,  4, 1'b0, 1'b0,  2, 1'b0, 16'd40, 1'b1,  7,  1};
    vecs[6] = '{ 3, 1'b1,  3,  2, -1, 1'b0, 1'b0, -1, 1'b0, 16'd17, 1'b0,  4,  1};
    vecs[7] = '{ 2, 1'b0,  1,  1,  1, 1'b0, 1'b0, -1, 1'b1, 16'd3,  1'b0,  3,  1};

    // Reset state.
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_ctl", 32'(ctl), 32'd0);
    chk("rst_res", 32'({res_valid, res_err, busy, op_ready}), 32'd0);
    chk("rst_res_data", 32'(res_data), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("post_rst_state", 32'(state), 32'(ST_IDLE));

    for (int i = 0; i < 7; i++) run_vec(i);

    // Reset in the middle of MAC, after the 10th operand handshake.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_len = 16'd20; cmd_relu = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    drive_ops(10, 21, 1, 1, 1, 1'b0, -1);
    @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    n_rv = 0; mon_en = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ctl", 32'(ctl), 32'd0);
    chk("mid_rst_operands", 32'({pe_x, pe_weight}), 32'd0);
    chk("mid_rst_flags", 32'({res_valid, res_err, busy, op_ready, cmd_ready}), 32'd0);
    chk("mid_rst_res_data", 32'(res_data), 32'd0);
    chk("mid_rst_state", 32'(state), 32'(ST_IDLE));
    op_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rel_state", 32'(state), 32'(ST_IDLE));
    repeat (20) @(negedge clk);
    mon_en = 1'b0;
    chk("rst_no_res_valid", 32'(n_rv), 32'd0);

    // New job after reset, with a stray command held high while busy.
    run_vec(7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
